dct8_mac_engine: RTL

- Parametrised 1-D 8-point DCT-II engine. Fetches 8 signed samples from a block RAM using a base address and a stride, then computes all 8 coefficients on a single time-shared multiply-accumulate (MAC). Writes the 8 results back to an output RAM using a base address and a stride.
- With stride 1 or 8, one engine performs either the row pass or the column pass of an 8x8 JPEG block. The block sits between the pixel EBR and the quantiser, with the same fetch/result memory interface style as the existing DCT.

---
 rtl/dct_pkg.sv | 34 +++
 rtl/dct8_coef_rom.sv | 22 ++
 rtl/dct8_mac_engine.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - Q14 DCT-II coefficient table, coefficient scaling helper and FSM states
package dct_pkg;

  localparam int COEF_Q = 14;

  // Entry [8*k + n] = round(2^14 * 0.5 * c(k) * cos((2n+1)k*pi/16)).
  localparam int COEF_Q14 [64] = '{
     5793,  5793,  5793,  5793,  5793,  5793,  5793,  5793,
     8035,  6811,  4551,  1598, -1598, -4551, -6811, -8035,
     7568,  3135, -3135, -7568, -7568, -3135,  3135,  7568,
     6811, -1598, -8035, -4551,  4551,  8035,  1598, -6811,
     5793, -5793, -5793,  5793,  5793, -5793, -5793,  5793,
     4551, -8035,  1598,  6811, -6811, -1598,  8035, -4551,
     3135, -7568,  7568, -3135, -3135,  7568, -7568,  3135,
     1598, -4551,  6811, -8035,  8035, -6811,  4551, -1598
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Round-half-up reduction of a Q14 entry to frac fractional bits.
  function automatic int coef_scale(input int q14, input int frac);
    int sh;
    sh = COEF_Q - frac;
    if (sh <= 0) return q14;
    return (q14 + (1 <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/dct8_coef_rom.sv
// rtl/dct8_coef_rom.sv - combinational (k, n) to C[k][n] coefficient lookup
module dct8_coef_rom
  import dct_pkg::*;
#(
  parameter int COEF_FRAC = 7
) (
  input  logic [2:0]               k,
  input  logic [2:0]               n,
  output logic signed [COEF_FRAC+1:0] coef
);

  localparam int CW = COEF_FRAC + 2;

  logic signed [CW-1:0] table_c [64];

  for (genvar i = 0; i < 64; i++) begin : g_tab
    assign table_c[i] = CW'(coef_scale(COEF_Q14[i], COEF_FRAC));
  end

  assign coef = table_c[{k, n}];

endmodule

// File: rtl/dct8_mac_engine.sv
// rtl/dct8_mac_engine.sv - 8-point DCT-II on one time-shared MAC; DCT8_SATURATE_EN clamps results
module dct8_mac_engine
  import dct_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int COEF_FRAC  = 7,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        in_base,
  input  logic [ADDR_WIDTH-1:0]        in_stride,
  input  logic [ADDR_WIDTH-1:0]        out_base,
  input  logic [ADDR_WIDTH-1:0]        out_stride,
  output logic [ADDR_WIDTH-1:0]        fetch_addr,
  input  logic signed [IN_WIDTH-1:0]   fetch_data,
  output logic                         fetch_clk,
  output logic signed [OUT_WIDTH-1:0]  result_out,
  output logic [ADDR_WIDTH-1:0]        result_addr,
  output logic                         result_wren,
  output logic                         result_clk,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = COEF_FRAC + 2;
  localparam int PW = IN_WIDTH + CW;
  localparam int AW = IN_WIDTH + COEF_FRAC + 5;
  localparam int RW = IN_WIDTH + 5;
  localparam logic signed [AW-1:0] HALF = AW'(longint'(1) <<< (COEF_FRAC - 1));

  state_t                  state;
  logic [3:0]              cnt;
  logic [2:0]              k_idx;
  logic [ADDR_WIDTH-1:0]   in_step;
  logic [ADDR_WIDTH-1:0]   out_step;
  logic [ADDR_WIDTH-1:0]   out_ptr;
  logic signed [IN_WIDTH-1:0] x [8];
  logic signed [AW-1:0]    acc;
  logic signed [CW-1:0]    coef;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    acc_sum;
  logic signed [RW-1:0]    rounded;
  logic signed [OUT_WIDTH-1:0] wr_value;

  assign fetch_clk  = clock;
  assign result_clk = clock;

  dct8_coef_rom #(.COEF_FRAC(COEF_FRAC)) u_rom (
    .k    (k_idx),
    .n    (cnt[2:0]),
    .coef (coef)
  );

  assign prod    = PW'(x[cnt[2:0]]) * PW'(coef);
  assign acc_sum = acc + AW'(prod);

  // Value for the write of output k, formed from the sum including the final term.
  always_comb begin
    rounded = RW'((acc_sum + HALF) >>> COEF_FRAC);
`ifdef DCT8_SATURATE_EN
    if (longint'(rounded) > (longint'(1) <<< (OUT_WIDTH - 1)) - 1)
      wr_value = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (longint'(rounded) < -(longint'(1) <<< (OUT_WIDTH - 1)))
      wr_value = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      wr_value = OUT_WIDTH'(rounded);
`else
    wr_value = OUT_WIDTH'(rounded);
`endif
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      k_idx       <= '0;
      in_step     <= '0;
      out_step    <= '0;
      out_ptr     <= '0;
      acc         <= '0;
      fetch_addr  <= '0;
      result_out  <= '0;
      result_addr <= '0;
      result_wren <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < 8; i++) x[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            fetch_addr <= in_base;
            in_step    <= in_stride;
            out_ptr    <= out_base;
            out_step   <= out_stride;
            cnt        <= '0;
            k_idx      <= '0;
            busy       <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Read data lags its address by one cycle, so cycle cnt captures sample cnt-1.
          if (cnt != 4'd0) x[cnt[2:0] - 3'd1] <= fetch_data;
          if (cnt < 4'd7) fetch_addr <= fetch_addr + in_step;
          if (cnt == 4'd8) begin
            cnt   <= '0;
            state <= ST_MAC;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_MAC: begin
          if (cnt[2:0] == 3'd7) begin
            result_out  <= wr_value;
            result_addr <= out_ptr;
            out_ptr     <= out_ptr + out_step;
            result_wren <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
            state       <= ST_WRITE;
          end else begin
            acc <= acc_sum;
            cnt <= cnt + 4'd1;
          end
        end
        ST_WRITE: begin
          result_wren <= 1'b0;
          if (k_idx == 3'd7) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            k_idx <= k_idx + 3'd1;
            state <= ST_MAC;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
